// File: rtl/adv7513_pkg.sv
// Shared 720p60 timing constants and pixel/run-state types for the ADV7513 video path.
package adv7513_pkg;

    localparam int H_ACTIVE = 1280;
    localparam int H_FP     = 110;
    localparam int H_SYNC   = 40;
    localparam int H_BP     = 220;
    localparam int V_ACTIVE = 720;
    localparam int V_FP     = 5;
    localparam int V_SYNC   = 5;
    localparam int V_BP     = 20;

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pxl_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } run_st_t;

endpackage

// File: rtl/adv7513_vid_tx_tmg_cntr.sv
// Free-running h/v raster counters with active/sync window decode (active, FP, sync, BP order).
module vid_tmg_cntr #(
    parameter int H_ACTIVE = adv7513_pkg::H_ACTIVE,
    parameter int H_FP     = adv7513_pkg::H_FP,
    parameter int H_SYNC   = adv7513_pkg::H_SYNC,
    parameter int H_BP     = adv7513_pkg::H_BP,
    parameter int V_ACTIVE = adv7513_pkg::V_ACTIVE,
    parameter int V_FP     = adv7513_pkg::V_FP,
    parameter int V_SYNC   = adv7513_pkg::V_SYNC,
    parameter int V_BP     = adv7513_pkg::V_BP
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic h_act_o,
    output logic v_act_o,
    output logic h_syn_o,
    output logic v_syn_o,
    output logic frm_beg_o,
    output logic frm_end_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYN_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYN_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYN_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYN_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;
    logic          h_wrap;

    assign h_wrap = (hcnt_q == H_LAST);

    always_comb begin
        hcnt_d = hcnt_q + 1'b1;
        vcnt_d = vcnt_q;
        if (h_wrap) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    assign h_act_o   = (hcnt_q < H_ACT_END);
    assign v_act_o   = (vcnt_q < V_ACT_END);
    assign h_syn_o   = (hcnt_q >= H_SYN_BEG) && (hcnt_q < H_SYN_END);
    assign v_syn_o   = (vcnt_q >= V_SYN_BEG) && (vcnt_q < V_SYN_END);
    assign frm_beg_o = (hcnt_q == '0) && (vcnt_q == '0);
    assign frm_end_o = h_wrap && (vcnt_q == V_LAST);

endmodule

// File: rtl/adv7513_vid_tx.sv
// ADV7513 pixel driver: frame-aligned run gating, FWFT pops, black on underflow, registered outputs.
module adv7513_vid_tx
    import adv7513_pkg::*;
#(
    parameter int   H_ACTIVE = adv7513_pkg::H_ACTIVE,
    parameter int   H_FP     = adv7513_pkg::H_FP,
    parameter int   H_SYNC   = adv7513_pkg::H_SYNC,
    parameter int   H_BP     = adv7513_pkg::H_BP,
    parameter int   V_ACTIVE = adv7513_pkg::V_ACTIVE,
    parameter int   V_FP     = adv7513_pkg::V_FP,
    parameter int   V_SYNC   = adv7513_pkg::V_SYNC,
    parameter int   V_BP     = adv7513_pkg::V_BP,
    parameter logic SYNC_POL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vid_en,
    input  logic        ff_empty,
    input  logic [23:0] ff_rdata,
    output logic        ff_rd_en,
    output logic        vid_hsync,
    output logic        vid_vsync,
    output logic        vid_de,
    output logic [23:0] vid_data,
    output logic        undrflw,
    output logic        frame_strt
);

    logic h_act, v_act, h_syn, v_syn, frm_beg, frm_end;

    vid_tmg_cntr #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_tmg (
        .clk_i     (clk),
        .rst_i     (rst),
        .h_act_o   (h_act),
        .v_act_o   (v_act),
        .h_syn_o   (h_syn),
        .v_syn_o   (v_syn),
        .frm_beg_o (frm_beg),
        .frm_end_o (frm_end)
    );

    run_st_t run_q, run_d;
    logic    undrflw_q, undrflw_d;
    logic    run_act, act_slot;
    logic    hs_q, vs_q, de_q, fs_q;
    pxl_t    pxl_q, pxl_d;

    // vid_en gates run combinationally so a drop stops pops and DE on the very next edge.
    assign run_act  = (run_q == ST_RUN) && vid_en;
    assign act_slot = run_act && h_act && v_act;
    assign ff_rd_en = act_slot && !ff_empty;

    always_comb begin
        run_d     = run_q;
        undrflw_d = undrflw_q;
        pxl_d     = '0;
        if (!vid_en) begin
            run_d     = ST_IDLE;
            undrflw_d = 1'b0;
        end else begin
            if ((run_q == ST_IDLE) && frm_end && !ff_empty) run_d = ST_RUN;
            if (act_slot && ff_empty) undrflw_d = 1'b1;
        end
        if (ff_rd_en) pxl_d = pxl_t'(ff_rdata);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q     <= ST_IDLE;
            undrflw_q <= 1'b0;
            hs_q      <= ~SYNC_POL;
            vs_q      <= ~SYNC_POL;
            de_q      <= 1'b0;
            fs_q      <= 1'b0;
            pxl_q     <= '0;
        end else begin
            run_q     <= run_d;
            undrflw_q <= undrflw_d;
            hs_q      <= h_syn ^ ~SYNC_POL;
            vs_q      <= v_syn ^ ~SYNC_POL;
            de_q      <= act_slot;
            fs_q      <= run_act && frm_beg;
            pxl_q     <= pxl_d;
        end
    end

    assign vid_hsync  = hs_q;
    assign vid_vsync  = vs_q;
    assign vid_de     = de_q;
    assign vid_data   = pxl_q;
    assign undrflw    = undrflw_q;
    assign frame_strt = fs_q;

endmodule

// File: tb/tb_adv7513_vid_tx.sv
// Directed bench for adv7513_vid_tx on a shrunken raster (28 x 11) so whole frames run quickly.
module tb_adv7513_vid_tx;

  localparam int HA = 16, HFP = 3, HS = 4, HBP = 5;
  localparam int VA = 6, VFP = 1, VS = 2, VBP = 2;
  localparam int HT = HA + HFP + HS + HBP;  // 28
  localparam int VT = VA + VFP + VS + VBP;  // 11
  localparam int FT = HT * VT;              // 308

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vid_en = 1'b0;
  logic        ff_empty = 1'b0;
  logic [23:0] ff_rdata;
  logic        ff_rd_en, vid_hsync, vid_vsync, vid_de, undrflw, frame_strt;
  logic [23:0] vid_data;

  adv7513_vid_tx #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_POL(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .vid_en(vid_en), .ff_empty(ff_empty), .ff_rdata(ff_rdata),
    .ff_rd_en(ff_rd_en), .vid_hsync(vid_hsync), .vid_vsync(vid_vsync), .vid_de(vid_de),
    .vid_data(vid_data), .undrflw(undrflw), .frame_strt(frame_strt)
  );

  // clock / reset
  always #5 clk = ~clk;

  // FWFT source: head pixel is the number of pops so far
  logic [23:0] pix = '0;
  always @(posedge clk) if (ff_rd_en === 1'b1) pix <= pix + 24'd1;
  assign ff_rdata = pix;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required finish before 200000");
    $fatal(1);
  end

  // scoreboard
  logic [23:0] exp_q[$];
  int n_chk = 0, n_fail = 0;
  int cnt = 0;
  int hs_cnt = 0, vs_cnt = 0, de_cnt = 0, fs_cnt = 0, pop_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (idx %0d)", nm, act, exp, cnt);
    end
  endtask

  function automatic int ix(input int f, input int v, input int h);
    return f * FT + v * HT + h;
  endfunction

  // one clock: record any pop, then check vid_data against the popped head
  task automatic step();
    logic        popped;
    logic [23:0] exp;
    #1;
    popped = (ff_rd_en === 1'b1) && !rst;
    if (popped) exp_q.push_back(ff_rdata);
    @(posedge clk);
    #1;
    cnt++;
    exp = popped ? exp_q.pop_front() : 24'h0;
    if (popped) pop_cnt++;
    if (vid_hsync === 1'b1) hs_cnt++;
    if (vid_vsync === 1'b1) vs_cnt++;
    if (vid_de === 1'b1) de_cnt++;
    if (frame_strt === 1'b1) fs_cnt++;
    chk("vid_data_sb", {8'h0, vid_data}, {8'h0, exp});
  endtask

  task automatic walk(input int idx);
    while (cnt < idx) step();
    #1;
  endtask

  task automatic chk_rst_vals(input string tag);
    chk({tag, "_de"}, vid_de, 1'b0);
    chk({tag, "_data"}, vid_data, 24'h0);
    chk({tag, "_hs"}, vid_hsync, 1'b0);
    chk({tag, "_vs"}, vid_vsync, 1'b0);
    chk({tag, "_fs"}, frame_strt, 1'b0);
    chk({tag, "_uf"}, undrflw, 1'b0);
    chk({tag, "_rd"}, ff_rd_en, 1'b0);
  endtask

  typedef struct {
    int          idx;
    logic        en;
    logic        emp;
    logic        rd;
    logic        de;
    logic        hs;
    logic        vs;
    logic        fs;
    logic        uf;
    logic [23:0] data;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input int idx, input logic en, input logic emp, input logic rd,
                              input logic de, input logic hs, input logic vs, input logic fs,
                              input logic uf, input logic [23:0] data);
    vec_t r;
    r.idx = idx; r.en = en; r.emp = emp; r.rd = rd; r.de = de;
    r.hs = hs; r.vs = vs; r.fs = fs; r.uf = uf; r.data = data;
    return r;
  endfunction

  initial begin
    //             idx            en  emp  rd   de   hs   vs   fs   uf   data
    vt.push_back(mk(ix(0,0,18),  0,  0,   0,   0,   0,   0,   0,   0,   24'd0));
    vt.push_back(mk(ix(0,0,19),  0,  0,   0,   0,   1,   0,   0,   0,   24'd0));
    vt.push_back(mk(ix(0,0,22),  0,  0,   0,   0,   1,   0,   0,   0,   24'd0));
    vt.push_back(mk(ix(0,0,23),  0,  0,   0,   0,   0,   0,   0,   0,   24'd0));
    vt.push_back(mk(ix(0,6,27),  0,  0,   0,   0,   0,   0,   0,   0,   24'd0));
    vt.push_back(mk(ix(0,7,0),   0,  0,   0,   0,   0,   1,   0,   0,   24'd0));
    vt.push_back(mk(ix(0,8,20),  0,  0,   0,   0,   1,   1,   0,   0,   24'd0));
    vt.push_back(mk(ix(0,9,0),   0,  0,   0,   0,   0,   0,   0,   0,   24'd0));
    vt.push_back(mk(ix(0,9,5),   1,  0,   0,   0,   0,   0,   0,   0,   24'd0));
    vt.push_back(mk(ix(0,10,27), 1,  0,   0,   0,   0,   0,   0,   0,   24'd0));
    vt.push_back(mk(ix(1,0,0),   1,  0,   1,   1,   0,   0,   1,   0,   24'd0));
    vt.push_back(mk(ix(1,0,1),   1,  0,   1,   1,   0,   0,   0,   0,   24'd1));
    vt.push_back(mk(ix(1,0,15),  1,  0,   1,   1,   0,   0,   0,   0,   24'h00000F));
    vt.push_back(mk(ix(1,0,16),  1,  0,   0,   0,   0,   0,   0,   0,   24'd0));
    vt.push_back(mk(ix(1,0,19),  1,  0,   0,   0,   1,   0,   0,   0,   24'd0));
    vt.push_back(mk(ix(1,5,15),  1,  0,   1,   1,   0,   0,   0,   0,   24'd95));
    vt.push_back(mk(ix(1,6,0),   1,  0,   0,   0,   0,   0,   0,   0,   24'd0));
    vt.push_back(mk(ix(1,7,3),   1,  0,   0,   0,   0,   1,   0,   0,   24'd0));
    vt.push_back(mk(ix(2,0,0),   1,  0,   1,   1,   0,   0,   1,   0,   24'd96));
    vt.push_back(mk(ix(2,1,0),   1,  0,   1,   1,   0,   0,   0,   0,   24'd112));

    // reset
    rst = 1'b1;
    step();
    step();
    chk_rst_vals("reset");
    rst = 1'b0;
    cnt = 0;
    hs_cnt = 0; vs_cnt = 0; de_cnt = 0; fs_cnt = 0; pop_cnt = 0;

    for (int i = 0; i < vt.size(); i++) begin
      vid_en   = vt[i].en;
      ff_empty = vt[i].emp;
      walk(vt[i].idx);
      chk("tbl_rd_en", ff_rd_en, vt[i].rd);
      step();
      chk("tbl_de", vid_de, vt[i].de);
      chk("tbl_hsync", vid_hsync, vt[i].hs);
      chk("tbl_vsync", vid_vsync, vt[i].vs);
      chk("tbl_frame_strt", frame_strt, vt[i].fs);
      chk("tbl_undrflw", undrflw, vt[i].uf);
      chk("tbl_data", vid_data, vt[i].data);
    end

    chk("cnt_hsync_hi", hs_cnt, 92);
    chk("cnt_vsync_hi", vs_cnt, 112);
    chk("cnt_de_hi", de_cnt, 113);
    chk("cnt_pops", pop_cnt, 113);
    chk("cnt_frame_strt", fs_cnt, 2);

    // underflow: 3 empty cycles mid-line
    walk(ix(2,2,5));
    ff_empty = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("uf_rd_en", ff_rd_en, 1'b0);
      step();
      chk("uf_de", vid_de, 1'b1);
      chk("uf_data", vid_data, 24'h0);
      chk("uf_flag", undrflw, 1'b1);
    end
    ff_empty = 1'b0;
    #1;
    chk("uf_resume_rd", ff_rd_en, 1'b1);
    step();
    chk("uf_resume_de", vid_de, 1'b1);
    chk("uf_resume_data", vid_data, 24'd133);
    walk(ix(2,3,0));
    step();
    chk("uf_sticky", undrflw, 1'b1);

    // drop vid_en mid-line
    walk(ix(2,3,10));
    vid_en = 1'b0;
    #1;
    chk("off_rd_en", ff_rd_en, 1'b0);
    step();
    chk("off_de", vid_de, 1'b0);
    chk("off_data", vid_data, 24'h0);
    chk("off_uf", undrflw, 1'b0);
    walk(ix(2,3,19));
    step();
    chk("off_hsync", vid_hsync, 1'b1);
    chk("off_de2", vid_de, 1'b0);

    // re-enable mid-frame waits for the boundary
    walk(ix(2,5,0));
    vid_en = 1'b1;
    step();
    chk("reen_de_wait", vid_de, 1'b0);
    walk(ix(3,0,0));
    chk("reen_rd", ff_rd_en, 1'b1);
    step();
    chk("reen_de", vid_de, 1'b1);
    chk("reen_fs", frame_strt, 1'b1);
    chk("reen_data", vid_data, 24'd151);

    // one-cycle reset mid-frame
    walk(ix(3,2,10));
    rst = 1'b1;
    step();
    rst = 1'b0;
    cnt = 0;
    chk_rst_vals("midrst");
    walk(ix(0,0,0));
    chk("midrst_rd0", ff_rd_en, 1'b0);
    step();
    chk("midrst_de0", vid_de, 1'b0);
    chk("midrst_fs0", frame_strt, 1'b0);
    walk(ix(0,0,19));
    step();
    chk("midrst_hsync", vid_hsync, 1'b1);
    walk(ix(0,5,3));
    step();
    chk("midrst_de_wait", vid_de, 1'b0);
    walk(ix(1,0,0));
    chk("midrst_rd1", ff_rd_en, 1'b1);
    step();
    chk("midrst_de1", vid_de, 1'b1);
    chk("midrst_fs1", frame_strt, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
